fifo_sync_flex: RTL and testbench

Single-clock, parametrised SRAM-backed FIFO. It is the successor to the dual-clock fifo_sram for same-domain buffering. It adds the following over fifo_sram:
- selectable read mode: standard registered read, or first-word-fall-through (FWFT);
- programmable almost-full and almost-empty thresholds;
- an occupancy count output;
- sticky overflow and underflow error flags.

It sits between a producer and a consumer in the same clock domain.

---
 rtl/fifo_pkg.sv | 9 +
 rtl/sram_dp_1r1w.sv | 21 ++
 rtl/fifo_sync_flex.sv | 98 +++++++++
 tb/tb_fifo_sync_flex.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode type, count-width helper and default thresholds for fifo_sync_flex
package fifo_pkg;
  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;
  localparam int DEF_AE_THR = 2;
  localparam int DEF_AF_MARGIN = 2;
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/sram_dp_1r1w.sv
// sram_dp_1r1w: 1W/1R storage array with registered read data; a colliding read returns the old word
module sram_dp_1r1w #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] wa,
  input  logic [WIDTH-1:0]         wd,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] ra,
  output logic [WIDTH-1:0]         q
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) q <= '0;
    else if (re) q <= mem[ra];
endmodule

// File: rtl/fifo_sync_flex.sv
// fifo_sync_flex: single-clock SRAM-backed FIFO with STD or FWFT read, thresholds, occupancy and sticky errors
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = 8,
  parameter int FWFT   = 0,
  parameter int AF_THR = DEPTH - DEF_AF_MARGIN,
  parameter int AE_THR = DEF_AE_THR
) (
  input  logic                      clk,
  input  logic                      rstb,
  input  logic                      wr_en,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      wr_full,
  output logic                      wr_almost_full,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          rd_data,
  output logic                      rd_val,
  output logic                      rd_empty,
  output logic                      rd_almost_empty,
  output logic [cnt_w(DEPTH)-1:0]   count,
  input  logic                      err_clr,
  output logic                      overflow,
  output logic                      underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AF_THR < 1 || AF_THR > DEPTH ||
      AE_THR < 0 || AE_THR > DEPTH - 1 || (FWFT != 0 && FWFT != 1)) begin : g_bad_param
    $error("fifo_sync_flex: illegal parameter set");
  end
  logic [AW-1:0]    wr_ptr, rd_ptr, ra;
  logic [CW-1:0]    cnt_next;
  logic             wr_acc, rd_acc, we, re, adv;
  logic [WIDTH-1:0] q;
  assign wr_full  = count == CW'(DEPTH);
  assign rd_empty = count == '0;
  assign wr_acc   = wr_en && !wr_full;
  assign rd_acc   = rd_en && !rd_empty;
  assign cnt_next = count + CW'(wr_acc) - CW'(rd_acc);
  sram_dp_1r1w #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_mem (
    .clk(clk), .rstb(rstb), .we(we), .wa(wr_ptr), .wd(wr_data), .re(re), .ra(ra), .q(q)
  );
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      count           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      wr_almost_full  <= 1'b0;
      rd_almost_empty <= 1'b1;
      overflow        <= 1'b0;
      underflow       <= 1'b0;
    end else begin
      count           <= cnt_next;
      wr_ptr          <= we ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr          <= adv ? rd_ptr + AW'(1) : rd_ptr;
      wr_almost_full  <= cnt_next >= CW'(AF_THR);
      rd_almost_empty <= cnt_next <= CW'(AE_THR);
      overflow        <= (wr_en && wr_full) || (overflow && !err_clr);
      underflow       <= (rd_en && rd_empty) || (underflow && !err_clr);
    end
  if (MODE == FIFO_STD) begin : g_std
    assign we      = wr_acc;
    assign adv     = rd_acc;
    assign re      = rd_acc;
    assign ra      = rd_ptr;
    assign rd_data = q;
    always_ff @(posedge clk or negedge rstb)
      if (!rstb) rd_val <= 1'b0;
      else rd_val <= rd_acc;
  end else begin : g_fwft
    // storage holds count minus the output-register entry; reads look one ahead so the next head is ready at pop
    logic             fwd, st_avail, load;
    logic [WIDTH-1:0] fwd_data;
    assign st_avail = count > CW'(rd_val);
    assign load     = !rd_val || rd_acc;
    assign adv      = load && st_avail;
    assign we       = wr_acc && !(load && !st_avail);
    assign re       = 1'b1;
    assign ra       = adv ? rd_ptr + AW'(1) : rd_ptr;
    always_ff @(posedge clk or negedge rstb)
      if (!rstb) begin
        rd_val   <= 1'b0;
        rd_data  <= '0;
        fwd      <= 1'b0;
        fwd_data <= '0;
      end else begin
        fwd      <= we && wr_ptr == ra;
        fwd_data <= wr_data;
        if (load) begin
          rd_val  <= st_avail || wr_acc;
          rd_data <= st_avail ? (fwd ? fwd_data : q) : (wr_acc ? wr_data : rd_data);
        end
      end
  end
endmodule

// File: tb/tb_fifo_sync_flex.sv
// tb_fifo_sync_flex: STD and FWFT instances on shared stimulus, checked against a queue model and vector table
module tb_fifo_sync_flex;
  logic clk_tb = 1'b0, rstb = 1'b0, wr_en = 1'b0, rd_en = 1'b0, err_clr = 1'b0;
  logic [7:0] wr_data = '0;
  logic s_full, s_af, s_val, s_empty, s_ae, s_ovf, s_unf;
  logic f_full, f_af, f_val, f_empty, f_ae, f_ovf, f_unf;
  logic [7:0] s_data, f_data;
  logic [3:0] s_count, f_count;
  int total = 0, bad = 0;
  int mq[$];
  int m_sdata = 0, m_sval = 0, m_fdata = 0, m_ovf = 0, m_unf = 0;
  typedef struct {
    int wr, rd, d, cnt, full, empty, af, ae, ovf, unf, sval, sdata, fval, fdata;
  } vec_t;
  vec_t tab[20];
  always #5 clk_tb = ~clk_tb;
  fifo_sync_flex #(.DEPTH(8), .WIDTH(8), .FWFT(0), .AF_THR(6), .AE_THR(2)) u_std (
    .clk(clk_tb), .rstb(rstb), .wr_en(wr_en), .wr_data(wr_data), .wr_full(s_full),
    .wr_almost_full(s_af), .rd_en(rd_en), .rd_data(s_data), .rd_val(s_val), .rd_empty(s_empty),
    .rd_almost_empty(s_ae), .count(s_count), .err_clr(err_clr), .overflow(s_ovf), .underflow(s_unf)
  );
  fifo_sync_flex #(.DEPTH(8), .WIDTH(8), .FWFT(1), .AF_THR(6), .AE_THR(2)) u_fwft (
    .clk(clk_tb), .rstb(rstb), .wr_en(wr_en), .wr_data(wr_data), .wr_full(f_full),
    .wr_almost_full(f_af), .rd_en(rd_en), .rd_data(f_data), .rd_val(f_val), .rd_empty(f_empty),
    .rd_almost_empty(f_ae), .count(f_count), .err_clr(err_clr), .overflow(f_ovf), .underflow(f_unf)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    m_sdata = 0; m_sval = 0; m_fdata = 0; m_ovf = 0; m_unf = 0;
  endtask
  task automatic model_step();
    int n = mq.size();
    bit wa = wr_en && n < 8;
    bit ra = rd_en && n > 0;
    m_ovf = int'((wr_en && n == 8) || (m_ovf != 0 && !err_clr));
    m_unf = int'((rd_en && n == 0) || (m_unf != 0 && !err_clr));
    m_sval = int'(ra);
    if (ra) m_sdata = mq.pop_front();
    if (wa) mq.push_back(int'(wr_data));
    if (mq.size() > 0) m_fdata = mq[0];
  endtask
  task automatic check_all();
    int n = mq.size();
    chk("std_count", s_count, n);        chk("fwft_count", f_count, n);
    chk("std_full", s_full, n == 8);     chk("fwft_full", f_full, n == 8);
    chk("std_empty", s_empty, n == 0);   chk("fwft_empty", f_empty, n == 0);
    chk("std_af", s_af, n >= 6);         chk("fwft_af", f_af, n >= 6);
    chk("std_ae", s_ae, n <= 2);         chk("fwft_ae", f_ae, n <= 2);
    chk("std_ovf", s_ovf, m_ovf);        chk("fwft_ovf", f_ovf, m_ovf);
    chk("std_unf", s_unf, m_unf);        chk("fwft_unf", f_unf, m_unf);
    chk("std_val", s_val, m_sval);       chk("std_data", s_data, m_sdata);
    chk("fwft_val", f_val, n > 0);       chk("fwft_data", f_data, m_fdata);
  endtask
  task automatic cycle();
    @(posedge clk_tb);
    model_step();
    #1;
    check_all();
  endtask
  task automatic drv(input int w, input int r, input int d, input int c);
    wr_en = (w != 0); rd_en = (r != 0); wr_data = 8'(d); err_clr = (c != 0);
    cycle();
    wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
  endtask
  task automatic drain();
    while (mq.size() > 0) drv(0, 1, 0, 0);
  endtask
  task automatic fill(input int base);
    while (mq.size() < 8) drv(1, 0, base + mq.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tab = '{
      '{1,0,1, 1,0,0,0,1,0,0,0,0,1,1}, '{1,0,2, 2,0,0,0,1,0,0,0,0,1,1},
      '{1,0,3, 3,0,0,0,0,0,0,0,0,1,1}, '{1,0,4, 4,0,0,0,0,0,0,0,0,1,1},
      '{1,0,5, 5,0,0,0,0,0,0,0,0,1,1}, '{1,0,6, 6,0,0,1,0,0,0,0,0,1,1},
      '{1,0,7, 7,0,0,1,0,0,0,0,0,1,1}, '{1,0,8, 8,1,0,1,0,0,0,0,0,1,1},
      '{1,0,9, 8,1,0,1,0,1,0,0,0,1,1}, '{1,0,10,8,1,0,1,0,1,0,0,0,1,1},
      '{0,1,0, 7,0,0,1,0,1,0,1,1,1,2}, '{0,1,0, 6,0,0,1,0,1,0,1,2,1,3},
      '{0,1,0, 5,0,0,0,0,1,0,1,3,1,4}, '{0,1,0, 4,0,0,0,0,1,0,1,4,1,5},
      '{0,1,0, 3,0,0,0,0,1,0,1,5,1,6}, '{0,1,0, 2,0,0,0,1,1,0,1,6,1,7},
      '{0,1,0, 1,0,0,0,1,1,0,1,7,1,8}, '{0,1,0, 0,0,1,0,1,1,0,1,8,0,8},
      '{0,1,0, 0,0,1,0,1,1,1,0,8,0,8}, '{0,1,0, 0,0,1,0,1,1,1,0,8,0,8}
    };
    #12;
    chk("rst_count", s_count, 0);  chk("rst_empty", s_empty, 1); chk("rst_ae", s_ae, 1);
    chk("rst_full", f_full, 0);    chk("rst_af", f_af, 0);       chk("rst_fval", f_val, 0);
    chk("rst_sdata", s_data, 0);   chk("rst_fdata", f_data, 0);  chk("rst_ovf", s_ovf, 0);
    check_all();
    rstb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drv(tab[i].wr, tab[i].rd, tab[i].d, 0);
      chk("tab_count", s_count, tab[i].cnt); chk("tab_full", s_full, tab[i].full);
      chk("tab_empty", s_empty, tab[i].empty); chk("tab_af", s_af, tab[i].af);
      chk("tab_ae", s_ae, tab[i].ae);        chk("tab_ovf", s_ovf, tab[i].ovf);
      chk("tab_unf", s_unf, tab[i].unf);     chk("tab_sval", s_val, tab[i].sval);
      chk("tab_sdata", s_data, tab[i].sdata); chk("tab_fval", f_val, tab[i].fval);
      chk("tab_fdata", f_data, tab[i].fdata); chk("tab_fcount", f_count, tab[i].cnt);
    end
    drv(0, 0, 0, 1);
    chk("clr_ovf", s_ovf, 0); chk("clr_unf", f_unf, 0);
    for (int i = 0; i < 4; i++) drv(1, 0, 20 + i, 0);
    drv(1, 1, 24, 0);
    chk("sim4_count", s_count, 4); chk("sim4_sdata", s_data, 20); chk("sim4_fdata", f_data, 21);
    fill(30);
    drv(1, 1, 99, 0);
    chk("simfull_count", s_count, 7); chk("simfull_ovf", s_ovf, 1); chk("simfull_fcount", f_count, 7);
    drain();
    drv(1, 1, 55, 0);
    chk("simempty_count", s_count, 1); chk("simempty_sval", s_val, 0);
    chk("simempty_fdata", f_data, 55); chk("simempty_unf", f_unf, 1);
    drv(0, 0, 0, 1);
    drain();
    drv(1, 0, 8'hA5, 0);
    chk("a5_fval", f_val, 1); chk("a5_fdata", f_data, 8'hA5);
    for (int i = 0; i < 16; i++) begin
      drv(1, 1, i + 1, 0);
      chk("byp_fval", f_val, 1); chk("byp_fdata", f_data, i + 1);
    end
    drv(1, 0, 17, 0);
    for (int i = 0; i < 16; i++) begin
      drv(1, 1, 18 + i, 0);
      chk("str_fval", f_val, 1); chk("str_fdata", f_data, 17 + i); chk("str_count", f_count, 2);
    end
    drain();
    fill(70);
    drv(1, 0, 77, 0);
    for (int i = 0; i < 5; i++) begin
      drv(0, 0, 0, 0);
      chk("hold_ovf", s_ovf, 1); chk("hold_fovf", f_ovf, 1);
    end
    drv(0, 0, 0, 1);
    chk("pulse_ovf", s_ovf, 0);
    drv(1, 0, 1, 1);
    chk("setwins_ovf", s_ovf, 1);
    drv(0, 0, 0, 1);
    drain();
    for (int i = 0; i < 5; i++) drv(1, 0, 60 + i, 0);
    chk("pre_rst_count", s_count, 5);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'd66;
    #3 rstb = 1'b0;
    #1;
    chk("arst_count", s_count, 0); chk("arst_fcount", f_count, 0);
    chk("arst_empty", s_empty, 1); chk("arst_fempty", f_empty, 1);
    chk("arst_sval", s_val, 0);    chk("arst_fval", f_val, 0);
    wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    #2 rstb = 1'b1;
    drv(1, 0, 8'h3C, 0);
    chk("post_fdata", f_data, 8'h3C);
    drv(0, 1, 0, 0);
    chk("post_sdata", s_data, 8'h3C); chk("post_sval", s_val, 1);
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 200; i++)
        drv(int'($urandom_range(0, 99) < 80 - 30 * p), int'($urandom_range(0, 99) < 20 + 30 * p),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 31) == 0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
